// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 default timing constants and helpers
package vga_timing_pkg;

    localparam int COUNT_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    // Inclusive range test used for the sync windows.
    function automatic logic in_span(input logic [COUNT_W-1:0] v,
                                     input logic [COUNT_W-1:0] lo,
                                     input logic [COUNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - enable-gated modulo counter for one scan axis
module vga_axis_counter #(
    parameter int LIMIT = 800,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    assign wrap = en && (count == LAST);

    // Advance on enable, returning to zero after the last position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA raster scan, sync generation and DAC output register
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] red_in,
    input  logic [9:0] green_in,
    input  logic [9:0] blue_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [9:0] vga_r,
    output logic [9:0] vga_g,
    output logic [9:0] vga_b,
    output logic       frame_tick
);

    localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_ACT    = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_LO    = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_HI    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_LO    = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_HI    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST_A = 10'(V_VISIBLE - 1);

    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       h_wrap;
    logic       frame_wrap_unused;
    logic       active;
    logic       hs_on;
    logic       vs_on;

    // Pixel enable runs at half the system clock; the DAC sees it as its clock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    vga_axis_counter #(.LIMIT(LINE_TOTAL), .WIDTH(COUNT_W)) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .count (hcount),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.LIMIT(FRAME_TOTAL), .WIDTH(COUNT_W)) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap),
        .count (vcount),
        .wrap  (frame_wrap_unused)
    );

    assign x          = hcount;
    assign y          = vcount;
    assign vga_clk    = pix_en;
    assign vga_sync_n = 1'b0;

    // Decode the position the renderer has just been presented with.
    always_comb begin
        active = (hcount < H_ACT) && (vcount < V_ACT);
        hs_on  = in_span(hcount, HS_LO, HS_HI);
        vs_on  = in_span(vcount, VS_LO, VS_HI);
    end

    // Register colour and sync together as x,y advance, so the DAC lags x,y by one pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (pix_en) begin
            vga_hs      <= ~hs_on;
            vga_vs      <= ~vs_on;
            vga_blank_n <= active;
            vga_r       <= active ? red_in   : '0;
            vga_g       <= active ? green_in : '0;
            vga_b       <= active ? blue_in  : '0;
        end
    end

    // One-clk pulse as the scan steps from the last visible line into vertical blanking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= h_wrap && (vcount == V_LAST_A);
        end
    end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter: H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter: H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter: H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter: H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter: V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter: V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter: V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter: V_BACK, default 33, vertical back porch in lines.
REQ-009 Port: clk, in, 1, 50 MHz system clock; all logic on its rising edge.
REQ-010 Port: reset, in, 1, reset, synchronous, active-low.
REQ-011 Port: red_in / green_in / blue_in, in, 10 each, colour from the background renderer for the current x,y.
REQ-012 Port: x / y, out, 10 each, current scan position driven to the renderer.
REQ-013 Port: vga_clk, out, 1, 25 MHz pixel clock to the DAC.
REQ-014 Port: vga_hs / vga_vs, out, 1 each, sync outputs, active-low.
REQ-015 Port: vga_blank_n / vga_sync_n, out, 1 each, DAC blank (low = blank) and composite sync (tied 0).
REQ-016 Port: vga_r / vga_g / vga_b, out, 10 each, registered colour to the DAC.
REQ-017 Port: frame_tick, out, 1, single-clk pulse at the start of vertical blanking.

Function
REQ-018 Internal pix_en shall toggle every clk; vga_clk shall equal pix_en.
REQ-019 hcount shall advance only on clk edges where pix_en==1 and wrap from H_TOTAL-1 (799) to 0.
REQ-020 vcount shall advance only when hcount wraps, and wrap from V_TOTAL-1 (524) to 0.
REQ-021 x shall equal hcount and y shall equal vcount; widths of 10 bits cover 0..799 without overflow.
REQ-022 Colour, sync and blank outputs shall be registered on the same pix_en edge, delayed one pixel from x,y to match the renderer's one-pixel latency.
REQ-023 On each pix_en edge, the registered vga_hs shall be 0 iff the delayed hcount is in 656..751.
REQ-024 On each pix_en edge, the registered vga_vs shall be 0 iff the delayed vcount is in 490..491.
REQ-025 vga_blank_n shall be 1 iff the delayed hcount<640 and delayed vcount<480.
REQ-026 vga_r/g/b shall equal the inputs when blank_n is 1, else 0.
REQ-027 frame_tick shall be 1 for exactly one clk on the pix_en edge where hcount wraps to 0 and vcount becomes 480.
REQ-028 Outputs shall change only on pix_en edges, giving one full clk of setup before the vga_clk rising edge.

Reset
REQ-029 While reset==0 at a clk edge: pix_en=0, hcount=0, vcount=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_r/g/b=0, frame_tick=0.
REQ-030 Reset asserted mid-line or mid-frame shall abort the frame; scanning shall restart at (0,0) on the second clk after release.

Structure
REQ-031 Package vga_timing_pkg shall hold the eight default timing constants and the derived H_TOTAL=800, V_TOTAL=525, HS_START/END and VS_START/END.
REQ-032 Sub-module vga_axis_counter (parameterised limit, enable in, count and wrap out) shall be instantiated twice, for h and v.

Verification
REQ-033 Release reset, run 2 frames -> hcount period 1600 clk, frame period 840000 clk, first vga_clk rise 2 clk after release.
REQ-034 Line timing: vga_hs low for exactly 192 clk per line, falling one pixel after x=656.
REQ-035 Frame timing: vga_vs low for exactly 2 lines (3200 clk), starting one pixel after y=490, x=0.
REQ-036 Drive red_in=10'h3FF constant -> vga_r=3FF only while blank_n=1, 0 during x>=640 or y>=480; 640x480 active pixels per frame.
REQ-037 frame_tick -> exactly one pulse per frame, coincident with y changing 479->480.
REQ-038 Assert reset at x=300,y=200 for 3 clk -> outputs take reset values; scanning resumes from (0,0) with no partial sync pulse.
